bounce_generator: RTL and testbench

Synthesizable contact-bounce emulator: the driving end of the debounce path. It takes a clean level (switch model or test pattern) and produces a realistic bouncing waveform on `bounce_out`, which feeds `debounce_circuit` (through its synchronizer) in on-board self-test and loop-back builds. Bursts are deterministic for a given seed: gap lengths come from an internal 8-bit LFSR, so a bench can predict every edge.

---
 rtl/bounce_generator.sv | 156 +++++++++++++++
 tb/tb_bounce_generator.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_generator.sv
// -----------------------------------------------------------------------------
// bounce_generator
//
// Contact-bounce emulator. Follows a clean target level and reproduces it on
// bounce_out as a burst of 2*BOUNCE_PAIRS+1 toggles. The gaps between toggles
// come from an 8-bit LFSR, so every edge is predictable for a given SEED.
//
// Parameters
//   BOUNCE_PAIRS : extra toggle pairs per burst (0..15, 0 = pass-through)
//   MIN_GAP      : minimum cycles between consecutive toggles (>= 1)
//   GAP_W        : random gap span in bits, gap = MIN_GAP + lfsr[GAP_W-1:0]
//   SEED         : LFSR reset value (8'h00 is replaced by 8'h01)
//
// Ports
//   clk        : in  - single clock, rising edge
//   reset      : in  - asynchronous, active-high, clears all state
//   clean_in   : in  - clean target level, synchronous to clk
//   bounce_out : out - registered bouncing level
//   busy       : out - high while a burst is in progress
//   settled    : out - one-cycle pulse on the edge of the final toggle
// -----------------------------------------------------------------------------
module bounce_generator #(
  parameter int         BOUNCE_PAIRS = 3,
  parameter int         MIN_GAP      = 2,
  parameter int         GAP_W        = 4,
  parameter logic [7:0] SEED         = 8'hA5
) (
  input  logic clk,
  input  logic reset,
  input  logic clean_in,
  output logic bounce_out,
  output logic busy,
  output logic settled
);

  // Wide enough for MIN_GAP + 2^GAP_W - 1 without wrap.
  localparam int         GAP_CW       = $clog2(MIN_GAP + (1 << GAP_W));
  localparam logic [7:0] SEED_EFF     = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [4:0] TOGGLES_INIT = 5'(2 * BOUNCE_PAIRS);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_BOUNCE = 1'b1;

  // Fibonacci LFSR step, x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0.
  // The all-zero guard is unreachable from a non-zero state but keeps the
  // register out of the lock-up state under any upset.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    logic [7:0] n;
    n = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    if (n == 8'h00) begin
      n = 8'h01;
    end else begin
      n = n;
    end
    return n;
  endfunction

  logic              clean_q;
  logic [7:0]        lfsr_q,    lfsr_d;
  logic [0:0]        state_q,   state_d;
  logic              target_q,  target_d;
  logic [4:0]        toggles_q, toggles_d;
  logic [GAP_CW-1:0] gap_q,     gap_d;
  logic              bounce_q,  bounce_d;
  logic              busy_q,    busy_d;
  logic              settled_q, settled_d;
  logic [GAP_CW-1:0] gap_load_s;

  // Counter reload value: one less than the gap, since the toggle edge itself
  // starts the count. Computed at full counter width.
  assign gap_load_s = GAP_CW'(MIN_GAP) + GAP_CW'(lfsr_q[GAP_W-1:0]) - GAP_CW'(1);

  assign lfsr_d = lfsr_next(lfsr_q);

  // Burst sequencing: start detection in IDLE, gap countdown and toggles in BOUNCE.
  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    toggles_d = toggles_q;
    gap_d     = gap_q;
    bounce_d  = bounce_q;
    busy_d    = busy_q;
    settled_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (clean_q != bounce_q) begin
          bounce_d = ~bounce_q;
          target_d = clean_q;
          if (BOUNCE_PAIRS == 0) begin
            // Single toggle is the whole burst.
            settled_d = 1'b1;
          end else begin
            toggles_d = TOGGLES_INIT;
            gap_d     = gap_load_s;
            busy_d    = 1'b1;
            state_d   = ST_BOUNCE;
          end
        end else begin
          bounce_d = bounce_q;
        end
      end
      ST_BOUNCE: begin
        if (gap_q != {GAP_CW{1'b0}}) begin
          gap_d = gap_q - GAP_CW'(1);
        end else begin
          toggles_d = toggles_q - 5'd1;
          if (toggles_q == 5'd1) begin
            // The burst has an odd toggle count, so the final toggle lands on target.
            bounce_d  = target_q;
            settled_d = 1'b1;
            busy_d    = 1'b0;
            state_d   = ST_IDLE;
          end else begin
            bounce_d = ~bounce_q;
            gap_d    = gap_load_s;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, counters, LFSR and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clean_q   <= 1'b0;
      lfsr_q    <= SEED_EFF;
      state_q   <= ST_IDLE;
      target_q  <= 1'b0;
      toggles_q <= 5'd0;
      gap_q     <= {GAP_CW{1'b0}};
      bounce_q  <= 1'b0;
      busy_q    <= 1'b0;
      settled_q <= 1'b0;
    end else begin
      clean_q   <= clean_in;
      lfsr_q    <= lfsr_d;
      state_q   <= state_d;
      target_q  <= target_d;
      toggles_q <= toggles_d;
      gap_q     <= gap_d;
      bounce_q  <= bounce_d;
      busy_q    <= busy_d;
      settled_q <= settled_d;
    end
  end

  assign bounce_out = bounce_q;
  assign busy       = busy_q;
  assign settled    = settled_q;

endmodule

// File: tb/tb_bounce_generator.sv
// -----------------------------------------------------------------------------
// tb_bounce_generator
//
// Three instances share clk/reset: dut (defaults), dut_s (SEED=0, same
// clean_in as dut) and dut_p (BOUNCE_PAIRS=0, pass-through). Predicted toggle
// events for dut/dut_s are pushed to per-instance queues when clean_in is
// driven and popped when a toggle or settled pulse is observed. The
// pass-through instance is checked from a hand-written vector table.
// -----------------------------------------------------------------------------
module tb_bounce_generator;

  localparam int BP = 3;
  localparam int MG = 2;
  localparam int GW = 4;

  typedef struct {
    int edge_n;
    bit val;
    bit set;
    bit busy;
    bit has_gap;
  } ev_t;

  typedef struct {
    logic c;
    logic bo;
    logic st;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic clean_in;
  logic clean_p;
  logic bo0, bz0, st0;
  logic bo1, bz1, st1;
  logic bop, bzp, stp;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  ev_t  sbq0[$];
  ev_t  sbq1[$];
  bit   prev_bo[2];
  int   last_t[2];
  int   ntog[2];

  always #5 clk = ~clk;

  // Edge counter: edge 1 is the first rising edge after reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  bounce_generator #(.BOUNCE_PAIRS(BP), .MIN_GAP(MG), .GAP_W(GW), .SEED(8'hA5)) dut (
    .clk(clk), .reset(reset), .clean_in(clean_in),
    .bounce_out(bo0), .busy(bz0), .settled(st0));

  bounce_generator #(.BOUNCE_PAIRS(BP), .MIN_GAP(MG), .GAP_W(GW), .SEED(8'h00)) dut_s (
    .clk(clk), .reset(reset), .clean_in(clean_in),
    .bounce_out(bo1), .busy(bz1), .settled(st1));

  bounce_generator #(.BOUNCE_PAIRS(0), .MIN_GAP(MG), .GAP_W(GW), .SEED(8'hA5)) dut_p (
    .clk(clk), .reset(reset), .clean_in(clean_p),
    .bounce_out(bop), .busy(bzp), .settled(stp));

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference LFSR value sampled on edge e (edge 1 sees the seed).
  function automatic logic [7:0] lfsr_at(input logic [7:0] seed, input int e);
    logic [7:0] v;
    v = seed;
    for (int j = 1; j < e; j++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return v;
  endfunction

  // Push the expected toggles of one burst; returns the edge of the final toggle.
  task automatic predict(input int i, input int first, input bit target, output int fin);
    ev_t        e;
    logic [7:0] seed;
    logic [7:0] v;
    int         t;
    seed = (i == 0) ? 8'hA5 : 8'h01;
    t = first;
    for (int k = 0; k <= 2 * BP; k++) begin
      e.edge_n  = t;
      e.val     = (k % 2 == 0) ? target : ~target;
      e.set     = (k == 2 * BP);
      e.busy    = (k != 2 * BP);
      e.has_gap = (k != 0);
      if (i == 0) sbq0.push_back(e);
      else        sbq1.push_back(e);
      if (k < 2 * BP) begin
        v = lfsr_at(seed, t);
        t = t + MG + int'(v[GW-1:0]);
      end
    end
    fin = t;
  endtask

  task automatic mon_one(input int i, input logic bo, input logic st, input logic bz);
    bit  tog;
    int  have;
    int  g;
    ev_t e;
    if (reset) begin
      prev_bo[i] = 1'b0;
      return;
    end
    tog = (bo != prev_bo[i]);
    if (tog || st) begin
      have = (i == 0) ? sbq0.size() : sbq1.size();
      chk($sformatf("inst%0d_event_expected", i), (have > 0) ? 1 : 0, 1);
      if (have > 0) begin
        e = (i == 0) ? sbq0.pop_front() : sbq1.pop_front();
        chk($sformatf("inst%0d_toggle_edge", i), cyc, e.edge_n);
        chk($sformatf("inst%0d_bounce_val", i), int'(bo), int'(e.val));
        chk($sformatf("inst%0d_settled", i), int'(st), int'(e.set));
        chk($sformatf("inst%0d_busy", i), int'(bz), int'(e.busy));
        if (e.has_gap) begin
          g = cyc - last_t[i];
          chk($sformatf("inst%0d_gap_in_range", i),
              (g >= MG && g <= MG + (1 << GW) - 1) ? 1 : 0, 1);
        end
      end
    end
    if (tog) begin
      ntog[i]++;
      last_t[i] = cyc;
    end
    prev_bo[i] = bo;
  endtask

  // Sample on the falling edge, then step 1ns so inputs can be driven.
  task automatic tick();
    @(negedge clk);
    mon_one(0, bo0, st0, bz0);
    mon_one(1, bo1, st1, bz1);
    #1;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while ((sbq0.size() + sbq1.size()) > 0 && n < limit) begin
      tick();
      n++;
    end
    chk("burst_done_within_budget", sbq0.size() + sbq1.size(), 0);
    sbq0.delete();
    sbq1.delete();
    repeat (4) tick();
  endtask

  initial begin
    vec_t tbl[12];
    int   f0, f1, d, first, n0, n1;

    tbl[0]  = '{1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b0};

    reset    = 1'b1;
    clean_in = 1'b1;
    clean_p  = 1'b0;
    repeat (3) tick();
    chk("reset_bounce_out", int'(bo0), 0);
    chk("reset_busy", int'(bz0), 0);
    chk("reset_settled", int'(st0), 0);
    chk("reset_bounce_out_seed0", int'(bo1), 0);
    chk("reset_bounce_out_pass", int'(bop), 0);

    // Release with clean_in already high: first toggle on edge 2.
    reset = 1'b0;
    predict(0, 2, 1'b1, f0);
    predict(1, 2, 1'b1, f1);
    wait_done(300);
    chk("rise_final_value", int'(bo0), 1);
    chk("rise_final_value_seed0", int'(bo1), 1);
    chk("rise_idle_busy", int'(bz0), 0);

    // Falling burst.
    clean_in = 1'b0;
    first = cyc + 2;
    predict(0, first, 1'b0, f0);
    predict(1, first, 1'b0, f1);
    wait_done(300);
    chk("fall_final_value", int'(bo0), 0);
    chk("fall_final_value_seed0", int'(bo1), 0);

    // Mid-burst change: first burst completes to 1, second starts right after settled.
    n0 = ntog[0];
    n1 = ntog[1];
    clean_in = 1'b1;
    first = cyc + 2;
    predict(0, first, 1'b1, f0);
    predict(1, first, 1'b1, f1);
    repeat (4) tick();
    clean_in = 1'b0;
    predict(0, f0 + 1, 1'b0, d);
    predict(1, f1 + 1, 1'b0, d);
    wait_done(600);
    chk("midburst_toggle_count", ntog[0] - n0, 14);
    chk("midburst_toggle_count_seed0", ntog[1] - n1, 14);
    chk("midburst_final_value", int'(bo0), 0);

    // Asynchronous reset in the middle of a burst.
    clean_in = 1'b1;
    first = cyc + 2;
    predict(0, first, 1'b1, f0);
    predict(1, first, 1'b1, f1);
    repeat (5) tick();
    chk("busy_before_async_reset", int'(bz0), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_bounce_out", int'(bo0), 0);
    chk("async_reset_busy", int'(bz0), 0);
    chk("async_reset_settled", int'(st0), 0);
    chk("async_reset_bounce_out_seed0", int'(bo1), 0);
    sbq0.delete();
    sbq1.delete();
    repeat (2) tick();
    // LFSR restarts from the seed, so the first run's gap sequence must repeat.
    reset = 1'b0;
    predict(0, 2, 1'b1, f0);
    predict(1, 2, 1'b1, f1);
    wait_done(300);
    chk("after_reset_final_value", int'(bo0), 1);

    // Pass-through instance: output follows clean_p one edge after it is sampled.
    for (int r = 0; r < 12; r++) begin
      clean_p = tbl[r].c;
      tick();
      chk($sformatf("pass_row%0d_bounce_out", r), int'(bop), int'(tbl[r].bo));
      chk($sformatf("pass_row%0d_settled", r), int'(stp), int'(tbl[r].st));
      chk($sformatf("pass_row%0d_busy", r), int'(bzp), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "timeout");
  end

endmodule
